// File: rtl/color_pkg.sv
// Shared colour constants, reset palette and FSM state encoding
// for the colour sequencer and its palette.
package color_pkg;

    localparam int COLOR_W = 12;

    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] YELLOW = 12'hFF0;

    // Entry 0 at LSB: R, G, B, Y
    localparam logic [47:0] DEFAULT_PALETTE = {YELLOW, BLUE, GREEN, RED};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/color_palette.sv
// Palette register file: 2**IDX_W entries, reset to PALETTE,
// one write port (we/waddr/wdata), NUM_RD combinational read ports.
module color_palette
    import color_pkg::*;
#(
    parameter int IDX_W   = 2,
    parameter int COLOR_W = color_pkg::COLOR_W,
    parameter int NUM_RD  = 5,
    parameter logic [(2**IDX_W)*COLOR_W-1:0] PALETTE = DEFAULT_PALETTE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [COLOR_W-1:0]        wdata,
    input  logic [NUM_RD*IDX_W-1:0]   raddr,
    output logic [NUM_RD*COLOR_W-1:0] rdata
);

    localparam int NUM_COLORS = 2**IDX_W;

    logic [COLOR_W-1:0] mem_q [NUM_COLORS];
    logic [COLOR_W-1:0] mem_d [NUM_COLORS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                mem_q[i] <= PALETTE[i*COLOR_W +: COLOR_W];
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see the pre-write contents in the cycle of a write
    always_comb begin
        rdata = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rdata[r*COLOR_W +: COLOR_W] = mem_q[raddr[r*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Latches packed colour indices, decodes them through a writable palette
// (full_color) and plays slots one by one on cur_color with on/gap timing.
// Ports: clk, rst, start, abort, color_vec, length, pal_we/addr/data in;
// full_color, cur_color, cur_valid, cur_slot, busy, done out (all registered).
module color_sequencer
    import color_pkg::*;
#(
    parameter int NUM_SLOTS  = 4,
    parameter int IDX_W      = 2,
    parameter int COLOR_W    = color_pkg::COLOR_W,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000,
    parameter logic [(2**IDX_W)*COLOR_W-1:0] PALETTE = DEFAULT_PALETTE,
    localparam int LEN_W  = $clog2(NUM_SLOTS + 1),
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_SLOTS*IDX_W-1:0]   color_vec,
    input  logic [LEN_W-1:0]             length,
    input  logic                         pal_we,
    input  logic [IDX_W-1:0]             pal_addr,
    input  logic [COLOR_W-1:0]           pal_data,
    output logic [NUM_SLOTS*COLOR_W-1:0] full_color,
    output logic [COLOR_W-1:0]           cur_color,
    output logic                         cur_valid,
    output logic [SLOT_W-1:0]            cur_slot,
    output logic                         busy,
    output logic                         done
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int NUM_RD  = NUM_SLOTS + 1;

    // Counters count down to 0, so load N-1 to stay N cycles
    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [SLOT_W-1:0]            slot_q, slot_d;
    logic [NUM_SLOTS*IDX_W-1:0]   vec_q, vec_d;
    logic [LEN_W-1:0]             len_q, len_d;
    logic [NUM_SLOTS*COLOR_W-1:0] full_color_q, full_color_d;
    logic [COLOR_W-1:0]           cur_color_q, cur_color_d;
    logic                         cur_valid_q, cur_valid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [LEN_W-1:0]             len_clamp;
    logic                         last_slot;
    logic [IDX_W-1:0]             cur_idx;
    logic [NUM_RD*IDX_W-1:0]      raddr;
    logic [NUM_RD*COLOR_W-1:0]    rdata;

    color_palette #(
        .IDX_W   (IDX_W),
        .COLOR_W (COLOR_W),
        .NUM_RD  (NUM_RD),
        .PALETTE (PALETTE)
    ) u_palette (
        .clk   (clk),
        .rst   (rst),
        .we    (pal_we),
        .waddr (pal_addr),
        .wdata (pal_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign len_clamp = (length > LEN_W'(NUM_SLOTS)) ? LEN_W'(NUM_SLOTS) : length;
    assign last_slot = (LEN_W'(slot_q) + LEN_W'(1)) == len_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        vec_d   = vec_q;
        len_d   = len_q;
        if (abort) begin
            state_d = IDLE;
            slot_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    slot_d = '0;
                    if (start) begin
                        vec_d = color_vec;
                        len_d = len_clamp;
                        if (len_clamp == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = SHOW;
                            cnt_d   = ON_LD;
                        end
                    end
                end
                SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (last_slot) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                        cnt_d  = ON_LD;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = SHOW;
                        slot_d  = slot_q + SLOT_W'(1);
                        cnt_d   = ON_LD;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up
    // with state_q; the shown slot reads via vec_d to cover the latch edge.
    assign cur_idx = vec_d[slot_d*IDX_W +: IDX_W];
    assign raddr   = {cur_idx, vec_q};

    always_comb begin
        full_color_d = rdata[NUM_SLOTS*COLOR_W-1:0];
        cur_valid_d  = (state_d == SHOW);
        cur_color_d  = cur_valid_d ? rdata[NUM_RD*COLOR_W-1 -: COLOR_W] : '0;
        busy_d       = (state_d == SHOW) || (state_d == GAP);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            slot_q       <= '0;
            vec_q        <= '0;
            len_q        <= '0;
            full_color_q <= '0;
            cur_color_q  <= '0;
            cur_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            vec_q        <= vec_d;
            len_q        <= len_d;
            full_color_q <= full_color_d;
            cur_color_q  <= cur_color_d;
            cur_valid_q  <= cur_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign full_color = full_color_q;
    assign cur_color  = cur_color_q;
    assign cur_valid  = cur_valid_q;
    assign cur_slot   = slot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Randomised self-checking bench for color_sequencer against a
// trace-level playback model (NUM_SLOTS=4, ON=3, GAP=2).
module tb_color_sequencer;

    localparam int ON  = 3;
    localparam int GP  = 2;
    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_SHOW = 2'd1;
    localparam logic [1:0] K_GAP  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst, start, abort, pal_we;
    logic [7:0]  color_vec;
    logic [2:0]  length;
    logic [1:0]  pal_addr;
    logic [11:0] pal_data;
    logic [47:0] full_color;
    logic [11:0] cur_color;
    logic        cur_valid;
    logic [1:0]  cur_slot;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] slot;
    } ent_t;

    int          tests = 0;
    int          errs  = 0;
    logic [11:0] pal_m [4];
    logic [7:0]  vec_m;
    ent_t        tr [$];

    color_sequencer #(
        .NUM_SLOTS  (4),
        .IDX_W      (2),
        .COLOR_W    (12),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .color_vec  (color_vec),
        .length     (length),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
        .full_color (full_color),
        .cur_color  (cur_color),
        .cur_valid  (cur_valid),
        .cur_slot   (cur_slot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pal_reset();
        pal_m[0] = 12'hF00;
        pal_m[1] = 12'h0F0;
        pal_m[2] = 12'h00F;
        pal_m[3] = 12'hFF0;
    endtask

    function automatic logic [47:0] decode(input logic [7:0] v,
                                           input logic [11:0] p [4]);
        logic [47:0] r;
        r = '0;
        for (int s = 0; s < 4; s++) begin
            r[s*12 +: 12] = p[v[s*2 +: 2]];
        end
        return r;
    endfunction

    // Expected playback: each slot ON cycles, GP blank between slots,
    // one DONE cycle, then IDLE.
    task automatic build(input int len);
        int n;
        ent_t e;
        n = (len > 4) ? 4 : len;
        tr.delete();
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < ON; c++) begin
                e.kind = K_SHOW; e.slot = 2'(s); tr.push_back(e);
            end
            if (s < n - 1) begin
                for (int c = 0; c < GP; c++) begin
                    e.kind = K_GAP; e.slot = 2'(s); tr.push_back(e);
                end
            end
        end
        e.kind = K_DONE; e.slot = 2'd0; tr.push_back(e);
        e.kind = K_IDLE; e.slot = 2'd0; tr.push_back(e);
    endtask

    task automatic tick_chk(input ent_t e, input bit latch);
        logic [11:0] snap [4];
        logic [47:0] fc;
        logic [11:0] col;
        logic        v, b, d;
        int          s;
        snap = pal_m;
        if (pal_we) pal_m[pal_addr] = pal_data;
        fc = decode(vec_m, snap);
        if (latch) vec_m = color_vec;
        @(posedge clk); #1;
        pal_we = 1'b0; start = 1'b0; abort = 1'b0;
        s   = int'(e.slot);
        v   = (e.kind == K_SHOW);
        b   = v || (e.kind == K_GAP);
        d   = (e.kind == K_DONE);
        col = v ? snap[vec_m[s*2 +: 2]] : 12'h000;
        chk("out", 48'({cur_valid, busy, done, cur_color}), 48'({v, b, d, col}));
        chk("full", full_color, fc);
        if (e.kind == K_SHOW || e.kind == K_IDLE)
            chk("slot", 48'(cur_slot), 48'(e.slot));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 48'({cur_valid, busy, done, cur_slot, cur_color}), 48'd0);
        chk({tag, "_full"}, full_color, 48'd0);
    endtask

    task automatic run_seq(input logic [7:0] vec, input logic [2:0] len,
                           input int abort_at, input bit use_rst,
                           input bit noise, input int wr_at);
        ent_t idle_e;
        idle_e = '0;
        color_vec = vec;
        length    = len;
        start     = 1'b1;
        build(int'(len));
        tick_chk(tr[0], 1'b1);
        for (int k = 1; k < tr.size(); k++) begin
            if (k == abort_at) begin
                if (use_rst) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    pal_reset();
                    vec_m = '0;
                    chk_zero("midrst");
                end else begin
                    abort = 1'b1;
                    start = 1'($urandom_range(0, 1));
                    tick_chk(idle_e, 1'b0);
                end
                tick_chk(idle_e, 1'b0);
                return;
            end
            if (k == wr_at) begin
                pal_we = 1'b1; pal_addr = 2'd3; pal_data = 12'hF0F;
            end
            if (noise) begin
                if ($urandom_range(0, 3) == 0) begin
                    pal_we   = 1'b1;
                    pal_addr = 2'($urandom);
                    pal_data = 12'($urandom);
                end
                start     = 1'($urandom_range(0, 1));
                color_vec = 8'($urandom);
                length    = 3'($urandom);
            end
            tick_chk(tr[k], 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pal_we = 1'b0;
        color_vec = '0; length = '0; pal_addr = '0; pal_data = '0;
        pal_reset();
        vec_m = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_full", full_color, 48'hF00_F00_F00_F00);
        chk("rel_busy", 48'(busy), 48'd0);

        run_seq(8'b11_10_01_00, 3'd4, -1, 1'b0, 1'b0, -1);
        chk("seq_full", full_color, 48'hFF0_00F_0F0_F00);
        run_seq(8'b11_10_01_00, 3'd0, -1, 1'b0, 1'b0, -1);
        run_seq(8'b01_11_00_10, 3'd7, -1, 1'b0, 1'b0, -1);
        run_seq(8'b11_10_01_00, 3'd4, 7, 1'b0, 1'b0, -1);
        run_seq(8'b11_10_01_00, 3'd4, -1, 1'b0, 1'b0, -1);
        run_seq(8'b00_00_00_11, 3'd1, -1, 1'b0, 1'b0, 1);
        chk("pal3", 48'(cur_color), 48'd0);
        run_seq(8'b00_00_00_11, 3'd2, 4, 1'b1, 1'b0, -1);
        run_seq(8'b00_00_00_11, 3'd1, -1, 1'b0, 1'b0, -1);
        run_seq(8'b00_11_10_01, 3'd3, -1, 1'b0, 1'b1, -1);

        for (int i = 0; i < 40; i++) begin
            int ab;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 14)) : -1;
            run_seq(8'($urandom), 3'($urandom), ab,
                    1'($urandom_range(0, 3) == 0), 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
